// File: rtl/fifo_sched_pkg.sv
// Shared types, default sizing and occupancy arithmetic for the
// two-producer round-robin FIFO write scheduler.
package fifo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam int DW_DEF        = 4;
    localparam int DEPTH_DEF     = 8;
    localparam int LW_DEF        = 4;
    localparam int MAX_BURST_DEF = 4;

    function automatic int unsigned next_level(input int unsigned lvl,
                                               input logic        wr,
                                               input logic        rd);
        if (wr && !rd) begin
            return lvl + 1;
        end
        if (rd && !wr) begin
            return lvl - 1;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/fifo_level_tracker.sv
// Mirrors FIFO occupancy, derives full/empty, gates consumer reads on empty
// and registers the read acknowledge.
module fifo_level_tracker
    import fifo_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LW    = LW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic          i_rd_req,
    output logic          o_rd_en,
    output logic          o_rd_ack,
    output logic [LW-1:0] o_level,
    output logic [LW-1:0] o_level_next,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [LW-1:0] r_level;
    logic          r_rd_ack;
    logic          w_rd_en;
    logic [LW-1:0] w_level_next;

    always_comb begin
        w_rd_en      = i_rd_req & (r_level != '0);
        w_level_next = LW'(next_level(32'(r_level), i_wr, w_rd_en));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level  <= '0;
            r_rd_ack <= 1'b0;
        end else begin
            r_level  <= w_level_next;
            r_rd_ack <= w_rd_en;
        end
    end

    assign o_rd_en      = w_rd_en;
    assign o_rd_ack     = r_rd_ack;
    assign o_level      = r_level;
    assign o_level_next = w_level_next;
    assign o_full       = (r_level == DEPTH_L);
    assign o_empty      = (r_level == '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (r_level <= DEPTH_L)
                else $error("occupancy above depth: %0d", r_level);
            assert (!(i_wr && (r_level == DEPTH_L)))
                else $error("write strobe while FIFO full");
        end
    end
`endif

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin, burst-limited arbitration of two producers onto one FIFO
// write port. Define FIFO_SCHED_STATS_EN to add per-producer stall counters.
module fifo_rr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int LW        = LW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in0_valid,
    input  logic [DW-1:0] in0_data,
    output logic          in0_ready,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    output logic          in1_ready,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic          fifo_wr_en,
    output logic [DW-1:0] fifo_wr_data,
    output logic          fifo_rd_en,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty,
    output logic          grant_id
`ifdef FIFO_SCHED_STATS_EN
    ,
    output logic [7:0]    stall0_cnt,
    output logic [7:0]    stall1_cnt
`endif
);

    localparam int            BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);

    state_t        r_state;
    logic [BW-1:0] r_burst;
    logic          r_last;
    logic          r_grant_id;

    logic          w_full;
    logic          w_empty;
    logic          w_rd_en;
    logic          w_rd_ack;
    logic [LW-1:0] w_level;
    logic [LW-1:0] w_level_next;

    logic          w_ready0;
    logic          w_ready1;
    logic          w_beat0;
    logic          w_beat1;
    logic          w_beat;
    logic          w_cur;
    logic          w_cur_valid;
    logic          w_oth_valid;
    logic          w_leave;
    logic          w_fill;
    logic [DW-1:0] w_wr_data;

    fifo_level_tracker #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_level (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr         (w_beat),
        .i_rd_req     (rd_req),
        .o_rd_en      (w_rd_en),
        .o_rd_ack     (w_rd_ack),
        .o_level      (w_level),
        .o_level_next (w_level_next),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    always_comb begin
        w_ready0    = (r_state == GNT0) & ~w_full;
        w_ready1    = (r_state == GNT1) & ~w_full;
        w_beat0     = in0_valid & w_ready0;
        w_beat1     = in1_valid & w_ready1;
        w_beat      = w_beat0 | w_beat1;
        w_cur       = (r_state == GNT1);
        w_cur_valid = w_cur ? in1_valid : in0_valid;
        w_oth_valid = w_cur ? in0_valid : in1_valid;
        w_leave     = ~w_cur_valid | (w_beat & (r_burst == BURST_LAST)) | w_full;
        // Hand-over is judged on post-cycle occupancy, so a read this cycle can free the slot.
        w_fill      = (w_level_next == DEPTH_L);
        w_wr_data   = '0;
        if (w_beat0) begin
            w_wr_data = in0_data;
        end else if (w_beat1) begin
            w_wr_data = in1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_burst    <= '0;
            r_last     <= 1'b1;
            r_grant_id <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_full) begin
                        if (in0_valid && in1_valid) begin
                            r_state    <= r_last ? GNT0 : GNT1;
                            r_grant_id <= ~r_last;
                        end else if (in0_valid) begin
                            r_state    <= GNT0;
                            r_grant_id <= 1'b0;
                        end else if (in1_valid) begin
                            r_state    <= GNT1;
                            r_grant_id <= 1'b1;
                        end
                    end
                end
                GNT0, GNT1: begin
                    if (w_leave) begin
                        r_last  <= w_cur;
                        r_burst <= '0;
                        if (w_oth_valid && !w_fill) begin
                            r_state    <= w_cur ? GNT0 : GNT1;
                            r_grant_id <= ~w_cur;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_beat) begin
                        r_burst <= r_burst + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in0_ready    = w_ready0;
    assign in1_ready    = w_ready1;
    assign fifo_wr_en   = w_beat;
    assign fifo_wr_data = w_wr_data;
    assign fifo_rd_en   = w_rd_en;
    assign rd_ack       = w_rd_ack;
    assign level        = w_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign grant_id     = r_grant_id;

`ifdef FIFO_SCHED_STATS_EN
    logic [7:0] r_stall0;
    logic [7:0] r_stall1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall0 <= '0;
            r_stall1 <= '0;
        end else begin
            if (in0_valid && !w_ready0 && (r_stall0 != '1)) begin
                r_stall0 <= r_stall0 + 1'b1;
            end
            if (in1_valid && !w_ready1 && (r_stall1 != '1)) begin
                r_stall1 <= r_stall1 + 1'b1;
            end
        end
    end

    assign stall0_cnt = r_stall0;
    assign stall1_cnt = r_stall1;
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed and randomized bench for fifo_rr_scheduler against a
// queue-based behavioural model of the arbitration and occupancy rules.
module tb_fifo_rr_scheduler;

    localparam int DEPTH = 8;
    localparam int MAXB  = 4;

    logic       clk;
    logic       rst_n;
    logic       in0_valid;
    logic [3:0] in0_data;
    logic       in0_ready;
    logic       in1_valid;
    logic [3:0] in1_data;
    logic       in1_ready;
    logic       rd_req;
    logic       rd_ack;
    logic       fifo_wr_en;
    logic [3:0] fifo_wr_data;
    logic       fifo_rd_en;
    logic [3:0] level;
    logic       full;
    logic       empty;
    logic       grant_id;

    int checks;
    int errors;

    // Behavioural model: owner -1 = nobody granted
    logic [3:0] m_fifo[$];
    int         m_owner;
    int         m_cnt;
    int         m_last;
    logic       m_grant;
    logic       m_ack;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    bit         rand_gate;
    bit         log_en;
    logic       glog[$];
    logic [3:0] wlog[$];

    fifo_rr_scheduler #(
        .DW        (4),
        .DEPTH     (DEPTH),
        .LW        (4),
        .MAX_BURST (MAXB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in0_valid    (in0_valid),
        .in0_data     (in0_data),
        .in0_ready    (in0_ready),
        .in1_valid    (in1_valid),
        .in1_data     (in1_data),
        .in1_ready    (in1_ready),
        .rd_req       (rd_req),
        .rd_ack       (rd_ack),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_rd_en   (fifo_rd_en),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1;
        m_grant = 1'b0;
        m_ack   = 1'b0;
    endtask

    task automatic zero_inputs();
        in0_valid = 1'b0;
        in0_data  = 4'h0;
        in1_valid = 1'b0;
        in1_data  = 4'h0;
        rd_req    = 1'b0;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        zero_inputs();
        @(negedge clk);
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit rd);
        int         lvl;
        int         nl;
        bit         v0;
        bit         v1;
        bit         mfull;
        bit         r0;
        bit         r1;
        bit         b0;
        bit         b1;
        bit         wr;
        bit         rde;
        bit         vx;
        bit         vy;
        logic [3:0] wd;
        @(negedge clk);
        v0 = (q0.size() > 0) && (!rand_gate || ($urandom_range(3) != 0));
        v1 = (q1.size() > 0) && (!rand_gate || ($urandom_range(3) != 0));
        in0_valid = v0;
        in0_data  = v0 ? q0[0] : 4'($urandom);
        in1_valid = v1;
        in1_data  = v1 ? q1[0] : 4'($urandom);
        rd_req    = rd;
        #1;
        lvl   = m_fifo.size();
        mfull = (lvl == DEPTH);
        r0    = (m_owner == 0) && !mfull;
        r1    = (m_owner == 1) && !mfull;
        b0    = v0 && r0;
        b1    = v1 && r1;
        wr    = b0 || b1;
        wd    = b0 ? in0_data : (b1 ? in1_data : 4'h0);
        rde   = rd && (lvl != 0);
        chk("in0_ready", in0_ready, r0);
        chk("in1_ready", in1_ready, r1);
        chk("wr_en", fifo_wr_en, wr);
        chk("wr_data", fifo_wr_data, wd);
        chk("rd_en", fifo_rd_en, rde);
        chk("rd_ack", rd_ack, m_ack);
        chk("level", level, lvl);
        chk("full", full, mfull);
        chk("empty", empty, lvl == 0);
        chk("grant_id", grant_id, m_grant);
        if (log_en && fifo_wr_en === 1'b1) begin
            glog.push_back(grant_id);
            wlog.push_back(fifo_wr_data);
        end
        nl = lvl + (wr ? 1 : 0) - (rde ? 1 : 0);
        if (m_owner < 0) begin
            if (!mfull) begin
                if (v0 && v1)  m_owner = 1 - m_last;
                else if (v0)   m_owner = 0;
                else if (v1)   m_owner = 1;
                if (m_owner >= 0) m_grant = (m_owner == 1);
            end
        end else begin
            vx = (m_owner == 0) ? v0 : v1;
            vy = (m_owner == 0) ? v1 : v0;
            if (!vx || (wr && m_cnt == MAXB - 1) || mfull) begin
                m_last = m_owner;
                m_cnt  = 0;
                if (vy && nl != DEPTH) begin
                    m_owner = 1 - m_owner;
                    m_grant = (m_owner == 1);
                end else begin
                    m_owner = -1;
                end
            end else if (wr) begin
                m_cnt++;
            end
        end
        if (rde) void'(m_fifo.pop_front());
        if (wr)  m_fifo.push_back(wd);
        m_ack = rde;
        if (b0) void'(q0.pop_front());
        if (b1) void'(q1.pop_front());
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rand_gate = 1'b0;
        log_en    = 1'b0;
        hold_reset();
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready0", in0_ready, 0);
        chk("rst_ready1", in1_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_grant", grant_id, 0);

        // single producer streams A,B,C
        release_reset();
        q0 = '{4'hA, 4'hB, 4'hC};
        log_en = 1'b1;
        wlog.delete();
        repeat (6) step(1'b0);
        log_en = 1'b0;
        chk("abc_level", level, 3);
        chk("abc_count", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("abc_d0", wlog[0], 4'hA);
            chk("abc_d1", wlog[1], 4'hB);
            chk("abc_d2", wlog[2], 4'hC);
        end

        // both producers saturated, consumer drains every cycle
        hold_reset();
        release_reset();
        for (int i = 0; i < 24; i++) begin
            q0.push_back(4'($urandom));
            q1.push_back(4'($urandom));
        end
        glog.delete();
        log_en = 1'b1;
        repeat (20) step(1'b1);
        log_en = 1'b0;
        chk("rr_beats", glog.size() >= 16, 1);
        if (glog.size() >= 16) begin
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("rr_grant%0d", k), glog[k], ((k / 4) % 2) == 1);
            end
        end

        // fill to depth with no reads
        hold_reset();
        release_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 10; i++) q0.push_back(4'(i + 1));
        repeat (14) step(1'b0);
        chk("fill_full", full, 1);
        chk("fill_level", level, 8);
        chk("fill_ready0", in0_ready, 0);
        chk("fill_no_wr", fifo_wr_en, 0);

        // read at full with producer still pending
        step(1'b1);
        chk("fr_rd_en", fifo_rd_en, 1);
        chk("fr_wr_blocked", fifo_wr_en, 0);
        step(1'b0);
        chk("fr_ack", rd_ack, 1);
        chk("fr_level7", level, 7);
        step(1'b0);
        chk("fr_refill_wr", fifo_wr_en, 1);
        step(1'b0);
        chk("fr_level8", level, 8);

        // read request against an empty FIFO, no bypass
        hold_reset();
        release_reset();
        q0.delete();
        step(1'b1);
        step(1'b1);
        chk("emp_rd_en", fifo_rd_en, 0);
        chk("emp_ack", rd_ack, 0);
        q0.push_back(4'h5);
        step(1'b1);
        step(1'b1);
        chk("emp_wr", fifo_wr_en, 1);
        chk("emp_no_bypass", fifo_rd_en, 0);
        step(1'b1);
        chk("emp_rd_after", fifo_rd_en, 1);
        step(1'b1);
        chk("emp_level0", level, 0);

        // asynchronous reset in the middle of a burst
        hold_reset();
        release_reset();
        for (int i = 0; i < 8; i++) q0.push_back(4'($urandom));
        repeat (7) step(1'b0);
        @(posedge clk);
        #2;
        chk("mid_level5", level, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_ready0", in0_ready, 0);
        chk("mid_rst_ready1", in1_ready, 0);
        chk("mid_rst_wr", fifo_wr_en, 0);
        chk("mid_rst_grant", grant_id, 0);
        zero_inputs();
        model_reset();
        release_reset();
        repeat (8) step(1'b0);

        // randomized traffic, fill-biased then drain-biased
        rand_gate = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (q0.size() < 3 && $urandom_range(1) == 1) q0.push_back(4'($urandom));
            if (q1.size() < 3 && $urandom_range(1) == 1) q1.push_back(4'($urandom));
            if (n < 200) step($urandom_range(2) == 0);
            else         step($urandom_range(2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
